regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised register file for the CPU datapath with a configurable number of read ports, registered (synchronous) read outputs, write-first bypass and a hardware clear sequence after reset. It sits in the decode stage and replaces the fixed 2-read/1-write 32x32 register file. Register operands are presented one cycle before they are consumed.

## Interface
- DATA_W, 32: width of each register entry and of each data port.
- ADDR_W, 5: address width. DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of independent read ports (1..4).
- clk_i  input  1  clock. All state is updated on the rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- rd_en_i  input  NUM_RD  per-port read enable. Bit p is port p.
- rd_addr_i  input  NUM_RD*ADDR_W  read addresses. Port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data_o  output  NUM_RD*DATA_W  registered read data. Port p occupies bits [p*DATA_W +: DATA_W].
- wr_en_i  input  1  write enable.
- wr_addr_i  input  ADDR_W  write address.
- wr_data_i  input  DATA_W  write data.
- ready_o  output  1  high when the clear sequence is complete and writes are accepted.

## Operation
- State machine with two states, CLEAR and RUN.
- Reset:
  - Asynchronous assertion forces the state to CLEAR, the clear counter to 0, rd_data_o to all-zero and ready_o to 0.
  - Array contents are not reset asynchronously.
- CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then increments clr_cnt.
  - After entry DEPTH-1 is written, the state moves to RUN and ready_o rises on the same edge.
  - CLEAR therefore lasts exactly DEPTH cycles after reset deassertion.
  - wr_en_i is ignored (the write is dropped, not queued).
  - Read ports with rd_en_i=1 load 0 into rd_data_o.
- RUN:
  - If wr_en_i=1, wr_data_i is written to entry wr_addr_i.
  - For each port p with rd_en_i[p]=1, rd_data_o[p] loads the entry at rd_addr_i[p].
  - If a port reads the address being written in the same cycle, it loads wr_data_i (write-first bypass).
  - Ports with rd_en_i[p]=0 hold their previous value.
- Multiple ports may read the same address in the same cycle. All of them return identical data.
- No arithmetic is performed. Data passes unmodified at DATA_W bits.
- Reset asserted mid-RUN restarts CLEAR from entry 0. All prior contents are considered lost.

## Timing
- Read latency: 1 cycle. The address sampled at edge N appears on rd_data_o after edge N and is stable until the next enabled read.
- Write latency: 1 cycle. Data written at edge N is readable from the array by a read sampled at edge N+1, and through the bypass by a read sampled at edge N.
- ready_o is 0 from reset assertion until the edge that clears entry DEPTH-1, and 1 afterwards.
- There is no combinational path from any input to any output.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - Entry 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, and the bypass never forwards for address 0.
- Not defined: entry 0 is an ordinary register.

## Test plan
- Reset then idle, DEPTH=32: ready_o=0 for exactly 32 cycles after rst_n_i rises, then 1. Reading all 32 addresses returns 0x00000000.
- CLEAR write attempt: wr_en_i=1, addr 3, data 0xDEADBEEF issued in cycle 5 of CLEAR; read addr 3 after ready_o=1 -> 0x00000000.
- Write then read: write 0x12345678 to addr 7. Port0 reads addr 7 next cycle and port1 reads addr 7 the cycle after. Both return 0x12345678, one cycle after their respective address sample.
- Same-cycle bypass: write 0xCAFEF00D to addr 9 while both ports read addr 9 in the same cycle -> both rd_data_o = 0xCAFEF00D after that edge. rd_en_i=0 on the following cycle -> outputs hold.
- Zero register:
  - With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to addr 0 with a same-cycle read of addr 0 -> 0, and a later read -> 0.
  - Without the macro: the same stimulus returns 0xFFFFFFFF in both cases.
- Mid-operation reset: write 0xA5A5A5A5 to addr 12, pulse rst_n_i low asynchronously between edges -> rd_data_o = 0 immediately and ready_o = 0. After 32 CLEAR cycles, read addr 12 -> 0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with registered read
// outputs, write-first bypass and a zero-fill clear sequence after reset.
// Optional feature macro: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     ready_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          clr_cnt_q, clr_cnt_d;
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]          mem_q [DEPTH];

  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_waddr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       wr_fire;
  logic [ADDR_W-1:0]          rd_addr;

  // A user write only lands in RUN; with the zero register, address 0 is never written.
`ifdef REGFILE_ZERO_REG_EN
  assign wr_fire = (state_q == StRun) && wr_en_i && (wr_addr_i != '0);
`else
  assign wr_fire = (state_q == StRun) && wr_en_i;
`endif

  // Next state, clear counter and array write port selection.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = wr_fire;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun: begin
        clr_cnt_d = clr_cnt_q;
      end
      default: state_d = StClear;
    endcase
  end

  // Per-port read data: hold when disabled, zero during clear, bypass on address match.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_addr   = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_addr = rd_addr_i[p*ADDR_W +: ADDR_W];
      if (rd_en_i[p]) begin
        if (state_q != StRun) begin
          rd_data_d[p*DATA_W +: DATA_W] = '0;
        end else if (wr_fire && (rd_addr == wr_addr_i)) begin
          rd_data_d[p*DATA_W +: DATA_W] = wr_data_i;
        end else begin
          rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr];
        end
`ifdef REGFILE_ZERO_REG_EN
        if (rd_addr == '0) begin
          rd_data_d[p*DATA_W +: DATA_W] = '0;
        end
`endif
      end
    end
  end

  // Control state and read output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array has no reset; the clear sequence zero-fills it instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data_o = rd_data_q;
  assign ready_o   = (state_q == StRun);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with a queue-based scoreboard for regfile_mp.
module tb_regfile_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NUM_RD = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] ZeroExp = 32'h0000_0000;
`else
  localparam logic [31:0] ZeroExp = 32'hFFFF_FFFF;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ready;

  regfile_mp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_RD(NUM_RD)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .ready_o  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // port 0/1 = rd_data lane, port 2 = ready_o
  typedef struct {
    int          due;
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int port, input logic [31:0] exp, input string name);
    exp_t e;
    e.due  = cyc + 1;
    e.port = port;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: after each edge, compare every expectation due by this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.port == 2) check(e.name, {63'd0, ready}, {32'd0, e.exp});
      else             check(e.name, {32'd0, rd_data[e.port*DATA_W +: DATA_W]}, {32'd0, e.exp});
    end
  end

  // Drive one cycle of inputs (called at posedge+1); chk masks which ports are scored.
  task automatic drive(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [1:0] chk, input logic [31:0] e0, input logic [31:0] e1,
                       input string name);
    rd_en   = en;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    if (chk[0]) push(0, e0, {name, "_p0"});
    if (chk[1]) push(1, e1, {name, "_p1"});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 2'b00, 32'd0, 32'd0, "idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_rd_data", rd_data, 64'd0);
    rst_n = 1'b1;

    // CLEAR: ready low for 31 edges, high after the 32nd; write in cycle 5 is dropped.
    for (int i = 1; i <= 32; i++) begin
      push(2, (i == 32) ? 32'd1 : 32'd0, "clear_ready");
      if (i == 5)      drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 32'hDEAD_BEEF, 2'b00, 0, 0, "clr_wr");
      else if (i == 2) drive(2'b11, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 2'b11, 0, 0, "clr_rd");
      else             idle();
    end

    // All entries read back as zero, including the dropped CLEAR write to addr 3.
    for (int j = 0; j < 16; j++) begin
      if (j == 0) push(2, 32'd1, "run_ready");
      drive(2'b11, 5'(2 * j), 5'(2 * j + 1), 1'b0, 5'd0, 32'd0, 2'b11, 32'd0, 32'd0,
            "zero_fill");
    end

    // Write then read on port 0, then port 1 (port 0 holds).
    drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1234_5678, 2'b00, 0, 0, "wr7");
    drive(2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 2'b01, 32'h1234_5678, 0, "rd7_p0");
    drive(2'b10, 5'd0, 5'd7, 1'b0, 5'd0, 32'd0, 2'b11, 32'h1234_5678, 32'h1234_5678,
          "rd7_p1");

    // Same-cycle bypass, then hold with rd_en low, then array read-back.
    drive(2'b11, 5'd9, 5'd9, 1'b1, 5'd9, 32'hCAFE_F00D, 2'b11, 32'hCAFE_F00D,
          32'hCAFE_F00D, "bypass9");
    drive(2'b00, 5'd9, 5'd9, 1'b1, 5'd9, 32'h1111_1111, 2'b11, 32'hCAFE_F00D,
          32'hCAFE_F00D, "hold");
    drive(2'b11, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 2'b11, 32'h1111_1111, 32'h1111_1111,
          "rd9");

    // Zero-register behaviour (expectation depends on the build macro).
    drive(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 2'b11, ZeroExp, ZeroExp, "zero_byp");
    drive(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 2'b11, ZeroExp, ZeroExp, "zero_rd");

    // Mid-operation reset between edges.
    drive(2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 32'hA5A5_A5A5, 2'b00, 0, 0, "wr12");
    drive(2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 32'd0, 2'b11, 32'hA5A5_A5A5, 32'hA5A5_A5A5,
          "rd12");
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rd_data", rd_data, 64'd0);
    check("midrst_ready", {63'd0, ready}, 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // First CLEAR edge already consumed; 31 more, ready rising on the last.
    for (int i = 2; i <= 32; i++) begin
      push(2, (i == 32) ? 32'd1 : 32'd0, "reclear_ready");
      idle();
    end
    drive(2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 32'd0, 2'b11, 32'd0, 32'd0, "rd12_after_rst");

    repeat (3) idle();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
